mem_arbiter: RTL and testbench

- Shares one single-port, byte-addressed unified memory between two requesters: instruction fetch (IF, read-only) and data load/store (D).
- The memory has combinational read and posedge-clock write of 4 bytes at `address`..`address+3`.
- Round-robin arbitration, one grant per idle cycle, registered responses.
- Sub-word stores become a read-modify-write sequence, because the memory always writes 4 bytes.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_store_merge.sv | 21 ++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-requester unified memory arbiter.
// Access sizes, FSM states, grant ids and the default idle address.
package mem_arbiter_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0100_0000;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } arb_state_e;

  // Size 11 is reserved and behaves as a full word.
  function automatic logic is_word_size(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/mem_arbiter_store_merge.sv
// Builds the word written back by a sub-word store: the old memory word
// with its low byte or low half replaced from right-justified store data.
module mem_arbiter_store_merge
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic [31:0] merged
);

  always_comb begin
    merged = wdata;
    case (size)
      SIZE_B:  merged = {old_word[31:8], wdata[7:0]};
      SIZE_H:  merged = {old_word[31:16], wdata[15:0]};
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data
// load/store; sub-word stores take an extra write cycle (read-modify-write).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter bit          RR_ENABLE = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        d_req_valid,
  input  logic        d_req_write,
  input  logic [1:0]  d_req_size,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_req_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        mem_read_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output arb_state_e  dbg_state
);

  // Handshake: a request is accepted in any cycle where valid and ready are
  // both high; ready is combinational and the requester must hold a stable
  // payload until then. Responses are single-cycle pulses with no ready.

  arb_state_e  state;
  arb_state_e  next_state;
  logic        last_grant;
  logic        grant_if;
  logic        grant_d;
  logic        d_is_rmw;
  logic [31:0] rmw_addr;
  logic [31:0] rmw_data;
  logic [31:0] merged;

  assign d_is_rmw  = d_req_write && !is_word_size(d_req_size);
  assign dbg_state = state;

  mem_arbiter_store_merge u_store_merge (
    .old_word (mem_data_out),
    .wdata    (d_req_wdata),
    .size     (d_req_size),
    .merged   (merged)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (grant_d && d_is_rmw) next_state = ST_RMW_WR;
      ST_RMW_WR: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_if       = 1'b0;
    grant_d        = 1'b0;
    mem_read_write = 1'b0;
    mem_address    = BASE_ADDR;
    mem_data_in    = 32'h0;
    case (state)
      ST_IDLE: begin
        if (!reset) begin
          if (if_req_valid && d_req_valid) begin
            if (RR_ENABLE && (last_grant == GRANT_D)) grant_if = 1'b1;
            else                                       grant_d  = 1'b1;
          end else begin
            grant_if = if_req_valid;
            grant_d  = d_req_valid;
          end
        end
        if (grant_if) begin
          mem_address = if_req_addr;
        end else if (grant_d) begin
          mem_address = d_req_addr;
          if (d_req_write && is_word_size(d_req_size)) begin
            mem_read_write = 1'b1;
            mem_data_in    = d_req_wdata;
          end
        end
      end
      ST_RMW_WR: begin
        // Reset must suppress the pending write so memory is left untouched.
        mem_read_write = !reset;
        mem_address    = rmw_addr;
        mem_data_in    = rmw_data;
      end
      default: ;
    endcase
  end

  assign if_req_ready = grant_if;
  assign d_req_ready  = grant_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant   <= GRANT_D;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= 32'h0;
      d_rsp_valid  <= 1'b0;
      d_rsp_data   <= 32'h0;
      rmw_addr     <= 32'h0;
      rmw_data     <= 32'h0;
    end else begin
      if (grant_if)     last_grant <= GRANT_IF;
      else if (grant_d) last_grant <= GRANT_D;

      if_rsp_valid <= grant_if;
      if (grant_if) if_rsp_data <= mem_data_out;

      d_rsp_valid <= (grant_d && !d_is_rmw) || (state == ST_RMW_WR);
      if (grant_d && !d_is_rmw) d_rsp_data <= d_req_write ? 32'h0 : mem_data_out;
      else if (state == ST_RMW_WR) d_rsp_data <= 32'h0;

      if (grant_d && d_is_rmw) begin
        rmw_addr <= d_req_addr;
        rmw_data <= merged;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed arbitration, store and
// reset cases plus a short random load/store run against a reference memory.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        d_req_valid;
  logic        d_req_write;
  logic [1:0]  d_req_size;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        mem_read_write;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  arb_state_e  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] if_exp_q[$];
  logic [31:0] d_exp_q[$];

  // Environment memory: 64 words, combinational read, posedge write.
  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] mem_off;
  assign mem_off      = mem_address - BASE;
  assign mem_data_out = mem[mem_off[7:2]];
  always @(posedge clock) if (mem_read_write) mem[mem_off[7:2]] <= mem_data_in;

  mem_arbiter #(.BASE_ADDR(BASE), .RR_ENABLE(1'b1)) dut (
    .clock          (clock),
    .reset          (reset),
    .if_req_valid   (if_req_valid),
    .if_req_addr    (if_req_addr),
    .if_req_ready   (if_req_ready),
    .if_rsp_valid   (if_rsp_valid),
    .if_rsp_data    (if_rsp_data),
    .d_req_valid    (d_req_valid),
    .d_req_write    (d_req_write),
    .d_req_size     (d_req_size),
    .d_req_addr     (d_req_addr),
    .d_req_wdata    (d_req_wdata),
    .d_req_ready    (d_req_ready),
    .d_rsp_valid    (d_rsp_valid),
    .d_rsp_data     (d_rsp_data),
    .mem_read_write (mem_read_write),
    .mem_address    (mem_address),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .dbg_state      (dbg_state)
  );

  // Clock / reset / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_merge(input logic [31:0] old_w, input logic [31:0] wd,
                                            input logic [1:0] sz);
    if (sz == 2'b00) return {old_w[31:8], wd[7:0]};
    if (sz == 2'b01) return {old_w[31:16], wd[15:0]};
    return wd;
  endfunction

  // Scoreboard: pop expected response data on every response pulse.
  always @(negedge clock) begin
    if (!reset) begin
      if (if_rsp_valid) begin
        if (if_exp_q.size() == 0) check("if_rsp_unexpected", 32'd1, 32'd0);
        else check("if_rsp_data", if_rsp_data, if_exp_q.pop_front());
      end
      if (d_rsp_valid) begin
        if (d_exp_q.size() == 0) check("d_rsp_unexpected", 32'd1, 32'd0);
        else check("d_rsp_data", d_rsp_data, d_exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic do_if(input logic [31:0] addr, input logic [31:0] exp_data);
    bit granted = 0;
    @(posedge clock); #1;
    if_req_valid = 1'b1;
    if_req_addr  = addr;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (if_req_ready) begin granted = 1; break; end
      @(posedge clock); #1;
    end
    if (!granted) begin
      check("if_grant_timeout", 32'd0, 32'd1);
      if_req_valid = 1'b0;
      return;
    end
    check("if_grant_addr", mem_address, addr);
    if_exp_q.push_back(exp_data);
    @(posedge clock); #1;
    if_req_valid = 1'b0;
    @(negedge clock);
    check("if_rsp_latency", 32'(if_rsp_valid), 32'd1);
    check("if_only_no_d_rsp", 32'(d_rsp_valid), 32'd0);
  endtask

  task automatic do_d(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rsp,
                      input logic [31:0] exp_merge);
    bit granted = 0;
    @(posedge clock); #1;
    d_req_valid = 1'b1;
    d_req_write = wr;
    d_req_size  = sz;
    d_req_addr  = addr;
    d_req_wdata = wd;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (d_req_ready) begin granted = 1; break; end
      @(posedge clock); #1;
    end
    if (!granted) begin
      check("d_grant_timeout", 32'd0, 32'd1);
      d_req_valid = 1'b0;
      return;
    end
    check("d_grant_we", 32'(mem_read_write), 32'(wr && sz[1]));
    check("d_grant_addr", mem_address, addr);
    if (wr && sz[1]) check("d_word_wdata", mem_data_in, wd);
    d_exp_q.push_back(exp_rsp);
    @(posedge clock); #1;
    d_req_valid = 1'b0;
    @(negedge clock);
    if (wr && !sz[1]) begin
      check("rmw_state", 32'(dbg_state), 32'(ST_RMW_WR));
      check("rmw_we", 32'(mem_read_write), 32'd1);
      check("rmw_addr", mem_address, addr);
      check("rmw_merged", mem_data_in, exp_merge);
      @(negedge clock);
    end
    check("d_rsp_latency", 32'(d_rsp_valid), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[0]  = 32'h0050_0093;
    mem[1]  = 32'h0000_1111;
    mem[8]  = 32'h1122_3344;
    mem[9]  = 32'h1122_3344;
    mem[10] = 32'hCAFE_F00D;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];

    reset        = 1'b1;
    if_req_valid = 1'b1;
    if_req_addr  = BASE;
    d_req_valid  = 1'b1;
    d_req_write  = 1'b0;
    d_req_size   = SIZE_W;
    d_req_addr   = BASE;
    d_req_wdata  = 32'h0;

    // Reset state, with both requesters asserted
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_if_ready", 32'(if_req_ready), 32'd0);
    check("rst_d_ready", 32'(d_req_ready), 32'd0);
    check("rst_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
    check("rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    check("rst_if_rsp_data", if_rsp_data, 32'h0);
    check("rst_d_rsp_data", d_rsp_data, 32'h0);
    check("rst_mem_we", 32'(mem_read_write), 32'd0);
    check("rst_mem_addr", mem_address, BASE);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Contention right after reset: IF, D, IF, D
    @(posedge clock); #1;
    reset       = 1'b0;
    if_req_addr = BASE;
    d_req_addr  = BASE + 32'h4;
    begin
      logic prev_if;
      prev_if = 1'b0;
      for (int i = 0; i < 4; i++) begin
        logic exp_if;
        exp_if = (i % 2 == 0);
        @(negedge clock);
        check("rr_if_ready", 32'(if_req_ready), 32'(exp_if));
        check("rr_d_ready", 32'(d_req_ready), 32'(!exp_if));
        if (i > 0) begin
          check("rr_if_rsp", 32'(if_rsp_valid), 32'(prev_if));
          check("rr_d_rsp", 32'(d_rsp_valid), 32'(!prev_if));
        end
        if (exp_if) if_exp_q.push_back(32'h0050_0093);
        else        d_exp_q.push_back(32'h0000_1111);
        prev_if = exp_if;
        @(posedge clock); #1;
      end
      if_req_valid = 1'b0;
      d_req_valid  = 1'b0;
      @(negedge clock);
      check("rr_last_d_rsp", 32'(d_rsp_valid), 32'd1);
      check("rr_last_if_rsp", 32'(if_rsp_valid), 32'd0);
    end

    // IF only
    do_if(BASE, 32'h0050_0093);

    // Word store, then fetch it back
    do_d(1'b1, SIZE_W, BASE + 32'h10, 32'hDEAD_BEEF, 32'h0, 32'h0);
    ref_mem[4] = 32'hDEAD_BEEF;
    do_if(BASE + 32'h10, 32'hDEAD_BEEF);

    // Byte store with a competing fetch arriving during the write cycle
    @(posedge clock); #1;
    d_req_valid = 1'b1;
    d_req_write = 1'b1;
    d_req_size  = SIZE_B;
    d_req_addr  = BASE + 32'h20;
    d_req_wdata = 32'h1234_56AB;
    @(negedge clock);
    check("sb_read_ready", 32'(d_req_ready), 32'd1);
    check("sb_read_we", 32'(mem_read_write), 32'd0);
    check("sb_read_addr", mem_address, BASE + 32'h20);
    d_exp_q.push_back(32'h0);
    @(posedge clock); #1;
    d_req_valid  = 1'b0;
    if_req_valid = 1'b1;
    if_req_addr  = BASE + 32'h20;
    @(negedge clock);
    check("sb_wr_state", 32'(dbg_state), 32'(ST_RMW_WR));
    check("sb_wr_we", 32'(mem_read_write), 32'd1);
    check("sb_wr_data", mem_data_in, 32'h1122_33AB);
    check("sb_wr_if_blocked", 32'(if_req_ready), 32'd0);
    check("sb_wr_d_blocked", 32'(d_req_ready), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("sb_rsp_valid", 32'(d_rsp_valid), 32'd1);
    check("sb_if_granted", 32'(if_req_ready), 32'd1);
    if_exp_q.push_back(32'h1122_33AB);
    ref_mem[8] = 32'h1122_33AB;
    @(posedge clock); #1;
    if_req_valid = 1'b0;
    @(negedge clock);
    check("sb_if_rsp", 32'(if_rsp_valid), 32'd1);

    // Half store, then fetch it back; then a plain load
    do_d(1'b1, SIZE_H, BASE + 32'h24, 32'h0000_BEEF, 32'h0, 32'h1122_BEEF);
    ref_mem[9] = 32'h1122_BEEF;
    do_if(BASE + 32'h24, 32'h1122_BEEF);
    do_d(1'b0, SIZE_W, BASE + 32'h4, 32'h0, 32'h0000_1111, 32'h0);

    // Random loads and stores over words 16..23
    for (int i = 0; i < 16; i++) begin
      logic [1:0]  sz;
      logic        wr;
      int          idx;
      logic [31:0] wd;
      logic [31:0] nw;
      sz  = 2'($urandom_range(0, 3));
      wr  = 1'($urandom_range(0, 1));
      idx = $urandom_range(16, 23);
      wd  = $urandom;
      nw  = ref_merge(ref_mem[idx], wd, sz);
      if (wr) begin
        do_d(1'b1, sz, BASE + 32'(idx * 4), wd, 32'h0, nw);
        ref_mem[idx] = nw;
      end else begin
        do_d(1'b0, sz, BASE + 32'(idx * 4), wd, ref_mem[idx], 32'h0);
      end
    end
    for (int idx = 16; idx < 24; idx++) do_if(BASE + 32'(idx * 4), ref_mem[idx]);

    // Reset arriving while the RMW write is pending
    @(posedge clock); #1;
    d_req_valid = 1'b1;
    d_req_write = 1'b1;
    d_req_size  = SIZE_B;
    d_req_addr  = BASE + 32'h28;
    d_req_wdata = 32'h0000_0055;
    @(negedge clock);
    check("rr_rmw_ready", 32'(d_req_ready), 32'd1);
    @(posedge clock); #1;
    d_req_valid = 1'b0;
    reset       = 1'b1;
    @(negedge clock);
    check("rst_rmw_we", 32'(mem_read_write), 32'd0);
    check("rst_rmw_ready", 32'(d_req_ready), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_rmw_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_rmw_mem", mem[10], 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      check("rst_rmw_no_rsp", 32'(d_rsp_valid), 32'd0);
      @(negedge clock);
    end
    do_if(BASE + 32'h28, 32'hCAFE_F00D);

    repeat (3) @(negedge clock);
    check("if_queue_drained", 32'(if_exp_q.size()), 32'd0);
    check("d_queue_drained", 32'(d_exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
